// File: rtl/ll_multi_queue.sv
// rtl/ll_multi_queue.sv - multiple linked-list queues sharing one node pool
module ll_multi_queue #(
    parameter int DATA_WD   = 16,
    parameter int DEPTH     = 16,
    parameter int NUM_LISTS = 4,
    localparam int PTR_WD   = $clog2(DEPTH),
    localparam int LID_WD   = (NUM_LISTS > 1) ? $clog2(NUM_LISTS) : 1,
    localparam int CNT_WD   = PTR_WD + 1
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 req_vld,
    input  logic [1:0]           req_type,
    input  logic [LID_WD-1:0]    req_list,
    input  logic [DATA_WD-1:0]   req_data,
    output logic                 intf_ready,
    output logic                 resp_vld,
    output logic [1:0]           resp_type,
    output logic [DATA_WD-1:0]   resp_data,
    output logic                 resp_data_vld,
    input  logic                 resp_taken,
    output logic [NUM_LISTS-1:0] list_empty,
    output logic [CNT_WD-1:0]    free_cnt
);

    typedef enum logic [1:0] {S_INIT, S_IDLE, S_EXEC, S_RESP} state_t;

    localparam logic [1:0] OP_PUSH  = 2'd0;
    localparam logic [1:0] OP_POP   = 2'd1;
    localparam logic [1:0] OP_PEEK  = 2'd2;
    localparam logic [1:0] OP_FLUSH = 2'd3;

    localparam logic [1:0] RC_OK    = 2'd0;
    localparam logic [1:0] RC_EMPTY = 2'd1;
    localparam logic [1:0] RC_FULL  = 2'd2;
    localparam logic [1:0] RC_BAD   = 2'd3;

    state_t state, state_nxt;

    logic [DATA_WD-1:0] data_mem [DEPTH];
    logic [PTR_WD-1:0]  nxt_mem  [DEPTH];

    logic [PTR_WD-1:0]  hd  [NUM_LISTS];
    logic [PTR_WD-1:0]  tl  [NUM_LISTS];
    logic [CNT_WD-1:0]  cnt [NUM_LISTS];
    logic [PTR_WD-1:0]  free_hd;
    logic [PTR_WD-1:0]  init_cnt;

    logic [1:0]         lat_type;
    logic [LID_WD-1:0]  lat_list;
    logic [DATA_WD-1:0] lat_data;

    logic               init_done;
    logic               is_exec;
    logic               list_bad;
    logic [LID_WD-1:0]  lid;
    logic [PTR_WD-1:0]  cur_hd;
    logic [PTR_WD-1:0]  cur_tl;
    logic [CNT_WD-1:0]  cur_cnt;
    logic               cur_empty;
    logic               pool_empty;
    logic               do_push;
    logic               do_pop;
    logic               do_flush;
    logic               nxt_we;
    logic [PTR_WD-1:0]  nxt_waddr;
    logic [1:0]         rc;
    logic               rd_vld;

    assign intf_ready = (state == S_IDLE);
    assign resp_vld   = (state == S_RESP);
    assign init_done  = (init_cnt == PTR_WD'(DEPTH - 1));

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_INIT;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: pool build, accept, single execute cycle, response hold
    always_comb begin
        state_nxt = state;
        case (state)
            S_INIT:  if (init_done) state_nxt = S_IDLE;
            S_IDLE:  if (req_vld) state_nxt = S_EXEC;
            S_EXEC:  state_nxt = S_RESP;
            S_RESP:  if (resp_taken) state_nxt = S_IDLE;
            default: state_nxt = S_INIT;
        endcase
    end

    // Decode of the latched request against current list and pool state
    always_comb begin
        is_exec    = (state == S_EXEC);
        list_bad   = ({{(32-LID_WD){1'b0}}, lat_list} >= 32'(NUM_LISTS));
        lid        = list_bad ? '0 : lat_list;
        cur_hd     = hd[lid];
        cur_tl     = tl[lid];
        cur_cnt    = cnt[lid];
        cur_empty  = (cur_cnt == '0);
        pool_empty = (free_cnt == '0);
        do_push    = is_exec && !list_bad && (lat_type == OP_PUSH) && !pool_empty;
        do_pop     = is_exec && !list_bad && (lat_type == OP_POP) && !cur_empty;
        do_flush   = is_exec && !list_bad && (lat_type == OP_FLUSH) && !cur_empty;
        // Every link rewrite in this design stores the current free-list head
        nxt_we     = do_pop || do_flush || (do_push && !cur_empty);
        nxt_waddr  = do_pop ? cur_hd : cur_tl;
        rd_vld     = !list_bad && ((lat_type == OP_POP) || (lat_type == OP_PEEK)) && !cur_empty;
        rc         = RC_OK;
        if (list_bad) begin
            rc = RC_BAD;
        end else if ((lat_type == OP_PUSH) && pool_empty) begin
            rc = RC_FULL;
        end else if (((lat_type == OP_POP) || (lat_type == OP_PEEK)) && cur_empty) begin
            rc = RC_EMPTY;
        end
    end

    // Node storage: link chain built during INIT, then updated by operations
    always_ff @(posedge clk) begin
        if (state == S_INIT) begin
            nxt_mem[init_cnt] <= init_cnt + 1'b1;
        end else if (nxt_we) begin
            nxt_mem[nxt_waddr] <= free_hd;
        end
        if (do_push) begin
            data_mem[free_hd] <= lat_data;
        end
    end

    // List pointers, free-list stack, request latch and response registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            init_cnt      <= '0;
            free_hd       <= '0;
            free_cnt      <= '0;
            lat_type      <= '0;
            lat_list      <= '0;
            lat_data      <= '0;
            resp_type     <= '0;
            resp_data     <= '0;
            resp_data_vld <= 1'b0;
            for (int i = 0; i < NUM_LISTS; i++) begin
                hd[i]  <= '0;
                tl[i]  <= '0;
                cnt[i] <= '0;
            end
        end else begin
            if (state == S_INIT) begin
                init_cnt <= init_cnt + 1'b1;
                if (init_done) begin
                    free_hd  <= '0;
                    free_cnt <= CNT_WD'(DEPTH);
                end
            end
            if ((state == S_IDLE) && req_vld) begin
                lat_type <= req_type;
                lat_list <= req_list;
                lat_data <= req_data;
            end
            if (is_exec) begin
                resp_type     <= rc;
                resp_data_vld <= rd_vld;
                resp_data     <= rd_vld ? data_mem[cur_hd] : '0;
            end
            if (do_push) begin
                free_hd  <= nxt_mem[free_hd];
                free_cnt <= free_cnt - 1'b1;
                if (cur_empty) begin
                    hd[lid] <= free_hd;
                end
                tl[lid]  <= free_hd;
                cnt[lid] <= cur_cnt + 1'b1;
            end
            if (do_pop) begin
                hd[lid]  <= nxt_mem[cur_hd];
                free_hd  <= cur_hd;
                free_cnt <= free_cnt + 1'b1;
                cnt[lid] <= cur_cnt - 1'b1;
            end
            if (do_flush) begin
                free_hd  <= cur_hd;
                free_cnt <= free_cnt + cur_cnt;
                cnt[lid] <= '0;
            end
        end
    end

    // Per-list empty flags
    always_comb begin
        list_empty = '0;
        for (int i = 0; i < NUM_LISTS; i++) begin
            list_empty[i] = (cnt[i] == '0);
        end
    end

endmodule

// File: tb/tb_ll_multi_queue.sv
// tb/tb_ll_multi_queue.sv - directed self-checking bench for ll_multi_queue
module tb_ll_multi_queue;

    localparam logic [1:0] OP_PUSH  = 2'd0;
    localparam logic [1:0] OP_POP   = 2'd1;
    localparam logic [1:0] OP_PEEK  = 2'd2;
    localparam logic [1:0] OP_FLUSH = 2'd3;
    localparam logic [1:0] RC_OK    = 2'd0;
    localparam logic [1:0] RC_EMPTY = 2'd1;
    localparam logic [1:0] RC_FULL  = 2'd2;
    localparam logic [1:0] RC_BAD   = 2'd3;

    logic        clk;
    logic        reset_n;
    logic        req_vld;
    logic [1:0]  req_type;
    logic [1:0]  req_list;
    logic [15:0] req_data;
    logic        intf_ready;
    logic        resp_vld;
    logic [1:0]  resp_type;
    logic [15:0] resp_data;
    logic        resp_data_vld;
    logic        resp_taken;
    logic [3:0]  list_empty;
    logic [3:0]  free_cnt;

    logic        b_req_vld;
    logic [1:0]  b_req_type;
    logic [1:0]  b_req_list;
    logic [15:0] b_req_data;
    logic        b_intf_ready;
    logic        b_resp_vld;
    logic [1:0]  b_resp_type;
    logic [15:0] b_resp_data;
    logic        b_resp_data_vld;
    logic        b_resp_taken;
    logic [2:0]  b_list_empty;
    logic [2:0]  b_free_cnt;

    int checks;
    int failures;

    ll_multi_queue #(.DATA_WD(16), .DEPTH(8), .NUM_LISTS(4)) dut (
        .clk(clk), .reset_n(reset_n),
        .req_vld(req_vld), .req_type(req_type), .req_list(req_list), .req_data(req_data),
        .intf_ready(intf_ready), .resp_vld(resp_vld), .resp_type(resp_type),
        .resp_data(resp_data), .resp_data_vld(resp_data_vld), .resp_taken(resp_taken),
        .list_empty(list_empty), .free_cnt(free_cnt)
    );

    // Three lists on a two-bit id leaves id 3 reachable for the bad-list path
    ll_multi_queue #(.DATA_WD(16), .DEPTH(4), .NUM_LISTS(3)) dut_b (
        .clk(clk), .reset_n(reset_n),
        .req_vld(b_req_vld), .req_type(b_req_type), .req_list(b_req_list), .req_data(b_req_data),
        .intf_ready(b_intf_ready), .resp_vld(b_resp_vld), .resp_type(b_resp_type),
        .resp_data(b_resp_data), .resp_data_vld(b_resp_data_vld), .resp_taken(b_resp_taken),
        .list_empty(b_list_empty), .free_cnt(b_free_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        reset_n    = 1'b0;
        req_vld    = 1'b0;
        resp_taken = 1'b0;
        #1;
        check("rst_ready", intf_ready, 0);
        check("rst_resp_vld", resp_vld, 0);
        check("rst_resp_type", resp_type, 0);
        check("rst_resp_data", resp_data, 0);
        check("rst_resp_dvld", resp_data_vld, 0);
        check("rst_free", free_cnt, 0);
        check("rst_empty", list_empty, 4'hF);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (k == 7) check("init_busy", intf_ready, 0);
        end
        check("init_ready", intf_ready, 1);
        check("init_free", free_cnt, 8);
        check("init_empty", list_empty, 4'hF);
    endtask

    task automatic wait_ready();
        int n;
        n = 0;
        while (!intf_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!intf_ready) check("ready_timeout", 0, 1);
    endtask

    task automatic wait_resp();
        int n;
        n = 0;
        while (!resp_vld && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!resp_vld) check("resp_timeout", 0, 1);
    endtask

    task automatic req_chk(input string tag, input logic [1:0] t, input logic [1:0] l,
                           input logic [15:0] d, input logic [1:0] exp_rt,
                           input logic [15:0] exp_rd, input logic exp_rdv);
        wait_ready();
        req_vld  = 1'b1;
        req_type = t;
        req_list = l;
        req_data = d;
        @(posedge clk);
        #1;
        req_vld = 1'b0;
        check({tag, "_early"}, resp_vld, 0);
        wait_resp();
        check({tag, "_type"}, resp_type, exp_rt);
        check({tag, "_dvld"}, resp_data_vld, exp_rdv);
        if (exp_rdv) check({tag, "_data"}, resp_data, exp_rd);
        resp_taken = 1'b1;
        @(posedge clk);
        #1;
        resp_taken = 1'b0;
    endtask

    initial begin
        int n;
        checks       = 0;
        failures     = 0;
        req_type     = '0;
        req_list     = '0;
        req_data     = '0;
        b_req_vld    = 1'b0;
        b_req_type   = '0;
        b_req_list   = '0;
        b_req_data   = '0;
        b_resp_taken = 1'b0;

        do_reset();

        // Two lists interleaved; FIFO order within list 1
        req_chk("push_a1", OP_PUSH, 2'd1, 16'h00A1, RC_OK, 16'h0, 1'b0);
        req_chk("push_a2", OP_PUSH, 2'd1, 16'h00A2, RC_OK, 16'h0, 1'b0);
        req_chk("push_b1", OP_PUSH, 2'd2, 16'h00B1, RC_OK, 16'h0, 1'b0);
        req_chk("pop_a1", OP_POP, 2'd1, 16'h0, RC_OK, 16'h00A1, 1'b1);
        req_chk("pop_a2", OP_POP, 2'd1, 16'h0, RC_OK, 16'h00A2, 1'b1);
        check("after_pops_empty", list_empty, 4'b1011);
        check("after_pops_free", free_cnt, 7);

        // Fill the pool completely, then overflow and underflow
        do_reset();
        for (int i = 0; i < 8; i++)
            req_chk("fill", OP_PUSH, 2'd0, 16'h0010 + 16'(i), RC_OK, 16'h0, 1'b0);
        req_chk("push_full", OP_PUSH, 2'd0, 16'h00FF, RC_FULL, 16'h0, 1'b0);
        check("full_free", free_cnt, 0);
        req_chk("pop_empty", OP_POP, 2'd3, 16'h0, RC_EMPTY, 16'h0, 1'b0);

        // Flush returns a whole chain to the pool in one step
        do_reset();
        for (int i = 0; i < 5; i++)
            req_chk("pre_flush", OP_PUSH, 2'd0, 16'h0020 + 16'(i), RC_OK, 16'h0, 1'b0);
        req_chk("flush0", OP_FLUSH, 2'd0, 16'h0, RC_OK, 16'h0, 1'b0);
        check("flush_free", free_cnt, 8);
        check("flush_empty", list_empty, 4'hF);
        req_chk("flush_again", OP_FLUSH, 2'd0, 16'h0, RC_OK, 16'h0, 1'b0);
        check("flush_again_free", free_cnt, 8);
        for (int i = 0; i < 8; i++)
            req_chk("refill3", OP_PUSH, 2'd3, 16'h0300 + 16'(i), RC_OK, 16'h0, 1'b0);
        check("refill_free", free_cnt, 0);
        for (int i = 0; i < 8; i++)
            req_chk("drain3", OP_POP, 2'd3, 16'h0, RC_OK, 16'h0300 + 16'(i), 1'b1);
        check("drain_free", free_cnt, 8);

        // Response held while not taken; requests during the hold are ignored
        req_chk("push_b1_again", OP_PUSH, 2'd2, 16'h00B1, RC_OK, 16'h0, 1'b0);
        wait_ready();
        req_vld  = 1'b1;
        req_type = OP_PEEK;
        req_list = 2'd2;
        @(posedge clk);
        #1;
        req_type = OP_PUSH;
        req_data = 16'h00EE;
        wait_resp();
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("hold_vld", resp_vld, 1);
            check("hold_type", resp_type, RC_OK);
            check("hold_data", resp_data, 16'h00B1);
            check("hold_dvld", resp_data_vld, 1);
            check("hold_ready", intf_ready, 0);
        end
        req_vld    = 1'b0;
        resp_taken = 1'b1;
        @(posedge clk);
        #1;
        resp_taken = 1'b0;
        check("peek_free", free_cnt, 7);
        check("peek_empty", list_empty, 4'b1011);

        // Stray resp_taken while idle has no effect
        resp_taken = 1'b1;
        @(posedge clk);
        #1;
        resp_taken = 1'b0;
        check("stray_taken_ready", intf_ready, 1);
        check("stray_taken_vld", resp_vld, 0);
        req_chk("pop_b1", OP_POP, 2'd2, 16'h0, RC_OK, 16'h00B1, 1'b1);
        req_chk("pop_b1_empty", OP_POP, 2'd2, 16'h0, RC_EMPTY, 16'h0, 1'b0);

        // Out-of-range list id on the three-list instance
        b_req_vld  = 1'b1;
        b_req_type = OP_PUSH;
        b_req_list = 2'd3;
        b_req_data = 16'h0055;
        n = 0;
        while (!b_intf_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #1;
        b_req_vld = 1'b0;
        n = 0;
        while (!b_resp_vld && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("bad_list_type", b_resp_type, RC_BAD);
        check("bad_list_dvld", b_resp_data_vld, 0);
        check("bad_list_free", b_free_cnt, 4);
        check("bad_list_empty", b_list_empty, 3'b111);
        b_resp_taken = 1'b1;
        @(posedge clk);
        #1;
        b_resp_taken = 1'b0;

        // Reset asserted while a push is executing
        req_chk("pre_abort", OP_PUSH, 2'd1, 16'h0077, RC_OK, 16'h0, 1'b0);
        wait_ready();
        req_vld  = 1'b1;
        req_type = OP_PUSH;
        req_list = 2'd1;
        req_data = 16'h0088;
        @(posedge clk);
        #1;
        req_vld = 1'b0;
        check("abort_in_exec", resp_vld, 0);
        do_reset();
        req_chk("abort_pop_empty", OP_POP, 2'd1, 16'h0, RC_EMPTY, 16'h0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
